// File: rtl/reset_seq_pkg.sv
// rtl/reset_seq_pkg.sv - shared state encoding and parameter limits for the reset sequencer
package reset_seq_pkg;

    typedef enum logic [1:0] {
        ST_HOLD  = 2'd0,
        ST_STAGE = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_e;

    localparam int CHANNELS_MIN    = 1;
    localparam int CHANNELS_MAX    = 16;
    localparam int HOLD_CYCLES_MIN = 1;
    localparam int STAGE_GAP_MIN   = 1;

    // Width needed to hold values 0..n, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// rtl/reset_sequencer_if.sv - staged reset outputs and soft reset request bundle
interface reset_sequencer_if #(
    parameter int CHANNELS = 3,
    parameter int CNT_W    = 32
);
    logic                soft_rst_i;
    logic [CHANNELS-1:0] rst_n_o;
    logic                all_released_o;
    logic [CNT_W-1:0]    cycle_cnt_o;
    logic                run_done_o;

    modport master (
        input  soft_rst_i,
        output rst_n_o,
        output all_released_o,
        output cycle_cnt_o,
        output run_done_o
    );

    modport slave (
        output soft_rst_i,
        input  rst_n_o,
        input  all_released_o,
        input  cycle_cnt_o,
        input  run_done_o
    );
endinterface

// File: rtl/rst_sync.sv
// rtl/rst_sync.sv - two-flop reset synchronizer, asynchronous assert and synchronous release
module rst_sync (
    input  logic clk_i,
    input  logic rst_n_i,
    output logic rst_n_o
);
    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= 1'b1;
            sync_q <= meta_q;
        end
    end

    assign rst_n_o = sync_q;
endmodule

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - holds, then releases channel resets one by one and times the run phase
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int CHANNELS    = 3,
    parameter int HOLD_CYCLES = 4,
    parameter int STAGE_GAP   = 2,
    parameter int RUN_CYCLES  = 1_000_000,
    parameter int CNT_W       = 32
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    reset_sequencer_if.master seq
);

    localparam int HW = cnt_w(HOLD_CYCLES);
    localparam int GW = cnt_w(STAGE_GAP);
    localparam int RW = cnt_w(CHANNELS);

    localparam logic [HW-1:0]    HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [GW-1:0]    GAP_LAST  = GW'(STAGE_GAP - 1);
    localparam logic [RW-1:0]    CH_LAST   = RW'(CHANNELS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    // A run target the saturating counter can never reach behaves like RUN_CYCLES=0.
    localparam longint CNT_MAX_L = (CNT_W >= 63) ? 64'h7fff_ffff_ffff_ffff
                                                 : (longint'(1) << CNT_W) - 1;
    localparam bit               RUN_REACH = (RUN_CYCLES > 0) &&
                                             (longint'(RUN_CYCLES) <= CNT_MAX_L);
    localparam logic [CNT_W-1:0] RUN_TGT   = CNT_W'(RUN_CYCLES);

    if (CHANNELS < CHANNELS_MIN || CHANNELS > CHANNELS_MAX) begin : g_bad_channels
        $error("reset_sequencer: CHANNELS must be within 1..16");
    end
    if (HOLD_CYCLES < HOLD_CYCLES_MIN) begin : g_bad_hold
        $error("reset_sequencer: HOLD_CYCLES must be at least 1");
    end
    if (STAGE_GAP < STAGE_GAP_MIN) begin : g_bad_gap
        $error("reset_sequencer: STAGE_GAP must be at least 1");
    end

    logic sync_rst_n;

    rst_sync u_rst_sync (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .rst_n_o (sync_rst_n)
    );

    seq_state_e       state_q, state_d;
    logic [HW-1:0]    hold_q,  hold_d;
    logic [GW-1:0]    gap_q,   gap_d;
    logic [RW-1:0]    rel_q,   rel_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [CNT_W-1:0] cnt_inc;

    always_ff @(posedge clk_i or negedge sync_rst_n) begin
        if (!sync_rst_n) begin
            state_q <= ST_HOLD;
            hold_q  <= '0;
            gap_q   <= '0;
            rel_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            gap_q   <= gap_d;
            rel_q   <= rel_d;
            cnt_q   <= cnt_d;
        end
    end

    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        gap_d   = gap_q;
        rel_d   = rel_q;
        cnt_d   = cnt_q;
        if (seq.soft_rst_i) begin
            state_d = ST_HOLD;
            hold_d  = '0;
            gap_d   = '0;
            rel_d   = '0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                ST_HOLD: begin
                    if (hold_q == HOLD_LAST) begin
                        hold_d = '0;
                        gap_d  = '0;
                        rel_d  = RW'(1);
                        cnt_d  = '0;
                        // A single channel passes through STAGE within this same edge.
                        state_d = (CHANNELS == 1) ? ST_RUN : ST_STAGE;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
                ST_STAGE: begin
                    if (gap_q == GAP_LAST) begin
                        gap_d = '0;
                        rel_d = rel_q + 1'b1;
                        if (rel_q == CH_LAST) begin
                            state_d = ST_RUN;
                            cnt_d   = '0;
                        end
                    end else begin
                        gap_d = gap_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    cnt_d = cnt_inc;
                    if (RUN_REACH && (cnt_inc == RUN_TGT)) begin
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: begin
                    cnt_d = cnt_inc;
                end
                default: begin
                    state_d = ST_HOLD;
                end
            endcase
        end
    end

    logic [CHANNELS-1:0] rst_n_out;
    logic                released_out;
    logic                done_out;

    // Channel i is released once more than i channels have been counted out.
    always_comb begin
        rst_n_out = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            rst_n_out[i] = (RW'(i) < rel_q);
        end
        released_out = (state_q == ST_RUN) || (state_q == ST_DONE);
        done_out     = (state_q == ST_DONE);
    end

    assign seq.rst_n_o        = rst_n_out;
    assign seq.all_released_o = released_out;
    assign seq.cycle_cnt_o    = cnt_q;
    assign seq.run_done_o     = done_out;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - directed self-checking bench for reset_sequencer
module tb_reset_sequencer;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic rst_n_a;
    logic rst_n_b;
    logic rst_n_c;

    int errors = 0;
    int checks = 0;

    reset_sequencer_if #(.CHANNELS(3), .CNT_W(32)) if_a ();
    reset_sequencer_if #(.CHANNELS(3), .CNT_W(3))  if_b ();
    reset_sequencer_if #(.CHANNELS(1), .CNT_W(8))  if_c ();

    reset_sequencer #(
        .CHANNELS(3), .HOLD_CYCLES(4), .STAGE_GAP(2), .RUN_CYCLES(5), .CNT_W(32)
    ) u_a (
        .clk_i   (clk),
        .rst_n_i (rst_n_a),
        .seq     (if_a)
    );

    reset_sequencer #(
        .CHANNELS(3), .HOLD_CYCLES(4), .STAGE_GAP(2), .RUN_CYCLES(0), .CNT_W(3)
    ) u_b (
        .clk_i   (clk),
        .rst_n_i (rst_n_b),
        .seq     (if_b)
    );

    reset_sequencer #(
        .CHANNELS(1), .HOLD_CYCLES(1), .STAGE_GAP(2), .RUN_CYCLES(2), .CNT_W(8)
    ) u_c (
        .clk_i   (clk),
        .rst_n_i (rst_n_c),
        .seq     (if_c)
    );

    // Expected values for HOLD_CYCLES=4, STAGE_GAP=2, RUN_CYCLES=5, CHANNELS=3.
    // e counts edges from the edge the block entered HOLD (first counting edge is e=1).
    function automatic logic [2:0] exp_rst(input int e);
        logic [2:0] r;
        r = 3'b000;
        for (int i = 0; i < 3; i++) begin
            if (e >= 4 + 2 * i) r[i] = 1'b1;
        end
        return r;
    endfunction

    function automatic logic exp_rel(input int e);
        return (e >= 8);
    endfunction

    function automatic int exp_cnt(input int e);
        return (e >= 8) ? e - 8 : 0;
    endfunction

    function automatic logic exp_done(input int e);
        return (e >= 13);
    endfunction

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (if_a.rst_n_o !== 3'b000 || if_a.all_released_o !== 1'b0 ||
            if_a.cycle_cnt_o !== 32'd0 || if_a.run_done_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_a: got rst=%b rel=%b cnt=%0d done=%b want 000/0/0/0",
                     if_a.rst_n_o, if_a.all_released_o, if_a.cycle_cnt_o, if_a.run_done_o);
        end
        checks++;
        if (if_b.rst_n_o !== 3'b000 || if_b.all_released_o !== 1'b0 ||
            if_b.cycle_cnt_o !== 3'd0 || if_b.run_done_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_b: got rst=%b rel=%b cnt=%0d done=%b want 000/0/0/0",
                     if_b.rst_n_o, if_b.all_released_o, if_b.cycle_cnt_o, if_b.run_done_o);
        end
        checks++;
        if (if_c.rst_n_o !== 1'b0 || if_c.all_released_o !== 1'b0 ||
            if_c.cycle_cnt_o !== 8'd0 || if_c.run_done_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_c: got rst=%b rel=%b cnt=%0d done=%b want 0/0/0/0",
                     if_c.rst_n_o, if_c.all_released_o, if_c.cycle_cnt_o, if_c.run_done_o);
        end
    endtask

    task automatic test_sequence();
        int e;
        @(negedge clk);
        rst_n_a = 1'b1;
        for (int edge_n = 1; edge_n <= 18; edge_n++) begin
            @(posedge clk);
            #1;
            e = edge_n - 2;
            checks++;
            if (if_a.rst_n_o !== exp_rst(e)) begin
                errors++;
                $display("FAIL seq_rst_n edge %0d: got %b want %b", edge_n, if_a.rst_n_o, exp_rst(e));
            end
            checks++;
            if (if_a.all_released_o !== exp_rel(e)) begin
                errors++;
                $display("FAIL seq_released edge %0d: got %b want %b", edge_n, if_a.all_released_o, exp_rel(e));
            end
            checks++;
            if (if_a.cycle_cnt_o !== 32'(exp_cnt(e))) begin
                errors++;
                $display("FAIL seq_cnt edge %0d: got %0d want %0d", edge_n, if_a.cycle_cnt_o, exp_cnt(e));
            end
            checks++;
            if (if_a.run_done_o !== exp_done(e)) begin
                errors++;
                $display("FAIL seq_done edge %0d: got %b want %b", edge_n, if_a.run_done_o, exp_done(e));
            end
        end
    endtask

    task automatic test_soft_reset();
        int e;
        @(negedge clk);
        if_a.soft_rst_i = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if (if_a.rst_n_o !== 3'b000 || if_a.all_released_o !== 1'b0 ||
                if_a.cycle_cnt_o !== 32'd0 || if_a.run_done_o !== 1'b0) begin
                errors++;
                $display("FAIL soft_hold edge %0d: got rst=%b rel=%b cnt=%0d done=%b want 000/0/0/0",
                         k, if_a.rst_n_o, if_a.all_released_o, if_a.cycle_cnt_o, if_a.run_done_o);
            end
        end
        @(negedge clk);
        if_a.soft_rst_i = 1'b0;
        for (int k = 1; k <= 22; k++) begin
            @(posedge clk);
            #1;
            e = (k <= 11) ? k : k - 12;
            checks++;
            if (if_a.rst_n_o !== exp_rst(e)) begin
                errors++;
                $display("FAIL soft_rst_n edge %0d: got %b want %b", k, if_a.rst_n_o, exp_rst(e));
            end
            checks++;
            if (if_a.all_released_o !== exp_rel(e)) begin
                errors++;
                $display("FAIL soft_released edge %0d: got %b want %b", k, if_a.all_released_o, exp_rel(e));
            end
            checks++;
            if (if_a.cycle_cnt_o !== 32'(exp_cnt(e))) begin
                errors++;
                $display("FAIL soft_cnt edge %0d: got %0d want %0d", k, if_a.cycle_cnt_o, exp_cnt(e));
            end
            checks++;
            if (if_a.run_done_o !== exp_done(e)) begin
                errors++;
                $display("FAIL soft_done edge %0d: got %b want %b", k, if_a.run_done_o, exp_done(e));
            end
            if (k == 11) begin
                @(negedge clk);
                if_a.soft_rst_i = 1'b1;
            end else if (k == 12) begin
                @(negedge clk);
                if_a.soft_rst_i = 1'b0;
            end
        end
    endtask

    task automatic test_async_reset();
        int e;
        @(negedge clk);
        if_a.soft_rst_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if_a.soft_rst_i = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (if_a.rst_n_o !== 3'b001 || if_a.all_released_o !== 1'b0) begin
            errors++;
            $display("FAIL async_pre_stage: got rst=%b rel=%b want 001/0", if_a.rst_n_o, if_a.all_released_o);
        end
        #5;
        rst_n_a = 1'b0;
        #1;
        checks++;
        if (if_a.rst_n_o !== 3'b000 || if_a.all_released_o !== 1'b0 ||
            if_a.cycle_cnt_o !== 32'd0 || if_a.run_done_o !== 1'b0) begin
            errors++;
            $display("FAIL async_drop: got rst=%b rel=%b cnt=%0d done=%b want 000/0/0/0",
                     if_a.rst_n_o, if_a.all_released_o, if_a.cycle_cnt_o, if_a.run_done_o);
        end
        @(negedge clk);
        rst_n_a = 1'b1;
        for (int edge_n = 1; edge_n <= 12; edge_n++) begin
            @(posedge clk);
            #1;
            e = edge_n - 2;
            checks++;
            if (if_a.rst_n_o !== exp_rst(e) || if_a.all_released_o !== exp_rel(e) ||
                if_a.cycle_cnt_o !== 32'(exp_cnt(e)) || if_a.run_done_o !== exp_done(e)) begin
                errors++;
                $display("FAIL async_restart edge %0d: got rst=%b rel=%b cnt=%0d done=%b want %b/%b/%0d/%b",
                         edge_n, if_a.rst_n_o, if_a.all_released_o, if_a.cycle_cnt_o, if_a.run_done_o,
                         exp_rst(e), exp_rel(e), exp_cnt(e), exp_done(e));
            end
        end
    endtask

    task automatic test_saturate();
        int e;
        int c;
        @(negedge clk);
        rst_n_b = 1'b1;
        for (int edge_n = 1; edge_n <= 24; edge_n++) begin
            @(posedge clk);
            #1;
            e = edge_n - 2;
            c = (e >= 8) ? ((e - 8 > 7) ? 7 : e - 8) : 0;
            checks++;
            if (if_b.rst_n_o !== exp_rst(e) || if_b.all_released_o !== exp_rel(e)) begin
                errors++;
                $display("FAIL sat_release edge %0d: got rst=%b rel=%b want %b/%b",
                         edge_n, if_b.rst_n_o, if_b.all_released_o, exp_rst(e), exp_rel(e));
            end
            checks++;
            if (if_b.cycle_cnt_o !== 3'(c)) begin
                errors++;
                $display("FAIL sat_cnt edge %0d: got %0d want %0d", edge_n, if_b.cycle_cnt_o, c);
            end
            checks++;
            if (if_b.run_done_o !== 1'b0) begin
                errors++;
                $display("FAIL sat_done edge %0d: got %b want 0", edge_n, if_b.run_done_o);
            end
        end
    endtask

    task automatic test_single_channel();
        logic exp_r;
        int   exp_c;
        logic exp_d;
        @(negedge clk);
        rst_n_c = 1'b1;
        for (int edge_n = 1; edge_n <= 6; edge_n++) begin
            @(posedge clk);
            #1;
            exp_r = (edge_n >= 3);
            exp_c = (edge_n >= 3) ? edge_n - 3 : 0;
            exp_d = (edge_n >= 5);
            checks++;
            if (if_c.rst_n_o !== exp_r || if_c.all_released_o !== exp_r) begin
                errors++;
                $display("FAIL single_release edge %0d: got rst=%b rel=%b want %b/%b",
                         edge_n, if_c.rst_n_o, if_c.all_released_o, exp_r, exp_r);
            end
            checks++;
            if (if_c.cycle_cnt_o !== 8'(exp_c) || if_c.run_done_o !== exp_d) begin
                errors++;
                $display("FAIL single_run edge %0d: got cnt=%0d done=%b want %0d/%b",
                         edge_n, if_c.cycle_cnt_o, if_c.run_done_o, exp_c, exp_d);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n_a = 1'b0;
        rst_n_b = 1'b0;
        rst_n_c = 1'b0;
        if_a.soft_rst_i = 1'b0;
        if_b.soft_rst_i = 1'b0;
        if_c.soft_rst_i = 1'b0;
        test_reset();
        test_sequence();
        test_soft_reset();
        test_async_reset();
        test_saturate();
        test_single_channel();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 SHALL have parameter CHANNELS, default 3: number of staged reset outputs (1..16).
REQ-002 SHALL have parameter HOLD_CYCLES, default 4: cycles all channels are held in reset after the synchronized reset release (>=1).
REQ-003 SHALL have parameter STAGE_GAP, default 2: cycles between consecutive channel releases (>=1).
REQ-004 SHALL have parameter RUN_CYCLES, default 1_000_000: run-phase length that sets run_done_o (0 disables done).
REQ-005 SHALL have parameter CNT_W, default 32: width of cycle_cnt_o.
REQ-006 SHALL have port clk_i, input, 1: single clock for all logic.
REQ-007 SHALL have port rst_n_i, input, 1: asynchronous active-low reset.
REQ-008 SHALL have port soft_rst_i, input, 1: synchronous request to re-run the sequence, active high.
REQ-009 SHALL have port rst_n_o, output, CHANNELS: per-channel active-low resets; bit 0 is released first.
REQ-010 SHALL have port all_released_o, output, 1: high once every channel is released.
REQ-011 SHALL have port cycle_cnt_o, output, CNT_W: cycles elapsed since all_released_o rose.
REQ-012 SHALL have port run_done_o, output, 1: sticky flag, set when the run phase reaches RUN_CYCLES.

Function
REQ-013 SHALL pass rst_n_i through a 2-flop synchronizer: assertion asynchronous, deassertion after 2 clk_i rising edges; the FSM and counters are reset by the synchronized signal.
REQ-014 SHALL implement FSM states HOLD, STAGE, RUN, DONE; the reset state is HOLD with hold counter 0.
REQ-015 HOLD: hold counter increments each edge; on the edge where it equals HOLD_CYCLES-1, go to STAGE and register rst_n_o[0]=1.
REQ-016 STAGE: rst_n_o[i] rises STAGE_GAP edges after rst_n_o[i-1]; on the edge the last channel rises, all_released_o rises and the state becomes RUN (or DONE if RUN_CYCLES=0 is not set … see REQ-018).
REQ-017 Therefore, counting rst_n_i deassertion edges from 1, rst_n_o[i] rises on edge 2+HOLD_CYCLES+i*STAGE_GAP; released channels stay high until reset or soft reset.
REQ-018 RUN: cycle_cnt_o is 0 on the release edge and increments by 1 per edge; on the edge it becomes RUN_CYCLES, go to DONE and set run_done_o; with RUN_CYCLES=0, the FSM stays in RUN and run_done_o never sets.
REQ-019 DONE: cycle_cnt_o keeps counting; run_done_o stays 1.
REQ-020 cycle_cnt_o SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-021 CHANNELS=1: STAGE is entered and left on the same edge; rst_n_o[0] and all_released_o rise together.
REQ-022 soft_rst_i sampled high in any state: on the next edge, all rst_n_o are 0, all_released_o=0, run_done_o=0, cycle_cnt_o=0, the counters are cleared, and the state becomes HOLD; the sequence then repeats per REQ-015..018 with edges counted from that edge.
REQ-023 soft_rst_i held high SHALL keep the block in HOLD with the hold counter at 0; release starts counting on the first edge it is sampled low.

Reset
REQ-024 While rst_n_i is low: rst_n_o all 0, all_released_o=0, run_done_o=0, cycle_cnt_o=0, state HOLD, regardless of clock.
REQ-025 rst_n_i asserted mid-sequence or mid-run SHALL drop all outputs immediately (asynchronously), then restart per REQ-013.

Structure
REQ-026 The state enum (HOLD/STAGE/RUN/DONE) SHALL live in shared package reset_seq_pkg, with parameter-range check constants.
REQ-027 The 2-flop synchronizer SHALL be a separate sub-module, rst_sync (ports clk_i, rst_n_i, rst_n_o), reused by other clock domains.
REQ-028 Parameter violations (HOLD_CYCLES<1, STAGE_GAP<1, CHANNELS outside 1..16) SHALL trigger an elaboration-time error.

Verification
REQ-029 Defaults, rst_n_i low 40 ns then high (20 ns clock) -> rst_n_o[0] rises at edge 6, [1] at edge 8, [2] at edge 10; all_released_o rises at edge 10.
REQ-030 RUN_CYCLES=5 -> cycle_cnt_o 0..5 on edges 10..15; run_done_o rises at edge 15 and stays high while the count continues.
REQ-031 soft_rst_i pulsed for 1 cycle at cycle_cnt_o=3 -> next edge: all outputs 0; channels re-release 4,6,8 edges later.
REQ-032 rst_n_i dropped asynchronously between edges during STAGE -> outputs 0 before the next edge; the full sequence repeats.
REQ-033 CNT_W=3, RUN_CYCLES=0 -> cycle_cnt_o saturates at 7, run_done_o stays 0.
REQ-034 CHANNELS=1, HOLD_CYCLES=1 -> rst_n_o[0] and all_released_o rise together on edge 3.
